rf_wb_arbiter: RTL and testbench
================================

// Module: rf_wb_arbiter
// PURPOSE
//  Shares the single register-file write port (write/addr/data) between two
//  writeback requesters: req0 = ALU result, req1 = memory load.
//  Round-robin arbitration with a valid/ready handshake per requester.
//  Registered output stage drives the RF write port.
//  Pending-write scoreboard (busy bit per register) lets issue logic stall on RAW/WAW hazards.
// PARAMETERS
//  DATA_W   16   register data width
//  ADDR_W   2    register address width
//  NREG     4    number of registers, must equal 2**ADDR_W
// PORTS
//  clk          in   1       single clock, all state updates on posedge
//  reset_n      in   1       asynchronous, active-low reset
//  req0_valid   in   1       ALU writeback request
//  req0_ready   out  1       ALU request accepted this cycle
//  req0_addr    in   ADDR_W  ALU destination register
//  req0_data    in   DATA_W  ALU result
//  req1_valid   in   1       load writeback request
//  req1_ready   out  1       load request accepted this cycle
//  req1_addr    in   ADDR_W  load destination register
//  req1_data    in   DATA_W  load data
//  issue_valid  in   1       issue stage reserves a destination register
//  issue_addr   in   ADDR_W  destination being reserved
//  rf_write     out  1       RF write enable
//  rf_addr      out  ADDR_W  RF write address
//  rf_data      out  DATA_W  RF write data
//  busy         out  NREG    busy[i]=1: write to register i is pending
//  err          out  1       sticky protocol-violation flag
// BEHAVIOUR
//  Reset (reset_n=0): applies immediately, with no clock edge needed.
//   - Outputs cleared: rf_write=0, rf_addr=0, rf_data=0, busy=0, err=0.
//   - Internal state: prio=0 (req0 favoured).
//   - Both ready outputs are forced to 0 while reset_n=0.
//   - A write accepted but not yet on the port is dropped.
//  Handshake: transfer occurs when valid&&ready are both high at a posedge.
//   - Readies are combinational from the valids and prio; at most one is high per cycle.
//   - A requester must hold addr/data stable while valid=1 and ready=0.
//   - valid must not depend on ready.
//  Arbitration:
//   - Both valid: grant the requester selected by prio.
//   - Only one valid: grant it.
//   - After any grant, prio <= index of the requester not granted.
//   - Full throughput: one grant per cycle; the output stage never stalls.
//  Latency:
//   - Handshake at edge N -> rf_write=1 with that addr/data during cycle N..N+1.
//   - rf_write drops to 0 the cycle after a cycle with no grant.
//   - RF commits at edge N+1; new data is readable from the RF after edge N+1.
//  Scoreboard, per register i, updated at each posedge:
//   - Set: issue_valid && issue_addr==i.
//   - Clear: write handshake with addr==i.
//   - Set and clear on the same edge: set wins, busy[i] stays 1.
//  Legality:
//   - Issue to i is legal if busy[i]==0, or a writeback handshake to i occurs the same cycle.
//   - Otherwise err<=1.
//   - A writeback handshake to a register with busy[i]==0 also sets err<=1;
//     the write is still performed.
//   - err is cleared only by reset.
//  Same-address contention (both requesters target the same register):
//   - Writes are serialized in grant order; the later grant's data is the final RF value.
// TESTING
//  1 Set busy=1010 with rf_write=1, then pulse reset_n low between edges
//    -> busy=0000, rf_write=0, err=0, readies 0 immediately.
//  2 Issue r2, then req0 valid addr=2 data=16'hABCD
//    -> req0_ready=1 that cycle; next cycle rf_write=1, rf_addr=2, rf_data=ABCD; busy[2] 1->0.
//  3 Both valid continuously, req0 (r1,16'h1111) and req1 (r3,16'h3333), destinations reissued each time
//    -> grants alternate 0,1,0,1; rf_data alternates 1111/3333; err=0.
//  4 req1 alone granted at edge N; both valid at edge N+1
//    -> req0 granted at N+1, req1 granted at N+2.
//  5 busy[1]=1; writeback r1 and issue r1 in the same cycle
//    -> busy[1] stays 1, err=0.
//  6 Issue r0 twice with no writeback between -> err=1, sticky across later clean traffic.
//    After reset, writeback r3 with busy[3]=0 -> err=1 and rf write to r3 still occurs.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the ALU and
// load writeback paths, with a registered output stage and a pending-write scoreboard.
module rf_wb_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 2,
    parameter int NREG   = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_addr,
    output logic              rf_write,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_data,
    output logic [NREG-1:0]   busy,
    output logic              err
);

    logic              prio;
    logic              vld_p0;
    logic [ADDR_W-1:0] addr_p0;
    logic [DATA_W-1:0] data_p0;
    logic [NREG-1:0]   set_mask;
    logic [NREG-1:0]   clr_mask;
    logic              issue_conflict;
    logic              wb_unreserved;

    // Stage p0: arbitration and handshake (readies are held low during reset)
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (reset_n) begin
            req0_ready = req0_valid && (!req1_valid || !prio);
            req1_ready = req1_valid && (!req0_valid ||  prio);
        end
    end

    always_comb begin
        vld_p0  = req0_ready || req1_ready;
        addr_p0 = req1_ready ? req1_addr : req0_addr;
        data_p0 = req1_ready ? req1_data : req0_data;
    end

    always_comb begin
        set_mask       = issue_valid ? (NREG'(1) << issue_addr) : '0;
        clr_mask       = vld_p0 ? (NREG'(1) << addr_p0) : '0;
        // Reissuing a register is fine when its pending write retires this same cycle.
        issue_conflict = issue_valid && busy[issue_addr] && !(vld_p0 && (addr_p0 == issue_addr));
        wb_unreserved  = vld_p0 && !busy[addr_p0];
    end

    // Stage p1: registered RF write port, priority, scoreboard and error flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rf_write <= 1'b0;
            rf_addr  <= '0;
            rf_data  <= '0;
            prio     <= 1'b0;
            busy     <= '0;
            err      <= 1'b0;
        end else begin
            rf_write <= vld_p0;
            if (vld_p0) begin
                rf_addr <= addr_p0;
                rf_data <= data_p0;
                prio    <= req0_ready;
            end
            busy <= (busy & ~clr_mask) | set_mask;
            if (issue_conflict || wb_unreserved)
                err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios plus randomized
// traffic compared against a behavioural model of the arbitration/scoreboard rules.
module tb_rf_wb_arbiter;

    logic        clk;
    logic        reset_n;
    logic        req0_valid, req0_ready;
    logic [1:0]  req0_addr;
    logic [15:0] req0_data;
    logic        req1_valid, req1_ready;
    logic [1:0]  req1_addr;
    logic [15:0] req1_data;
    logic        issue_valid;
    logic [1:0]  issue_addr;
    logic        rf_write;
    logic [1:0]  rf_addr;
    logic [15:0] rf_data;
    logic [3:0]  busy;
    logic        err;

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    logic [3:0]  m_busy;
    int          m_prio;
    logic        m_err;
    logic        exp_wr;
    logic [1:0]  exp_addr;
    logic [15:0] exp_data;
    logic        exp_r0, exp_r1;
    logic        obs_r0, obs_r1;

    rf_wb_arbiter #(.DATA_W(16), .ADDR_W(2), .NREG(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr), .req1_data(req1_data),
        .issue_valid(issue_valid), .issue_addr(issue_addr),
        .rf_write(rf_write), .rf_addr(rf_addr), .rf_data(rf_data),
        .busy(busy), .err(err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic model_reset();
        m_busy = '0; m_prio = 0; m_err = 1'b0;
        exp_wr = 1'b0; exp_addr = '0; exp_data = '0;
    endtask

    task automatic idle_inputs();
        req0_valid = 0; req0_addr = 0; req0_data = 0;
        req1_valid = 0; req1_addr = 0; req1_data = 0;
        issue_valid = 0; issue_addr = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        reset_n = 1'b0;
        #2 reset_n = 1'b1;
        model_reset();
    endtask

    // One clock cycle: drive at negedge, sample readies, advance model, end just after posedge.
    task automatic cycle(input logic v0, input logic [1:0] a0, input logic [15:0] d0,
                         input logic v1, input logic [1:0] a1, input logic [15:0] d1,
                         input logic iv, input logic [1:0] ia);
        int g;
        logic [1:0] ga;
        logic [15:0] gd;
        logic [3:0] nb;
        @(negedge clk);
        req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1;
        issue_valid = iv; issue_addr = ia;
        #1;
        obs_r0 = req0_ready;
        obs_r1 = req1_ready;
        g = -1;
        if (v0 && v1) g = m_prio;
        else if (v0)  g = 0;
        else if (v1)  g = 1;
        exp_r0 = (g == 0);
        exp_r1 = (g == 1);
        ga = (g == 1) ? a1 : a0;
        gd = (g == 1) ? d1 : d0;
        nb = m_busy;
        if (iv && m_busy[ia] && !(g >= 0 && ga == ia)) m_err = 1'b1;
        if (g >= 0 && !m_busy[ga]) m_err = 1'b1;
        if (g >= 0) nb[ga] = 1'b0;
        if (iv) nb[ia] = 1'b1;
        m_busy = nb;
        exp_wr = (g >= 0);
        if (g >= 0) begin
            m_prio = 1 - g;
            exp_addr = ga;
            exp_data = gd;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_n = 1'b0;
        #3;
        checks++;
        if ({rf_write, rf_addr, rf_data, busy, err} !== 24'h0) begin
            errors++; $display("FAIL reset_init: got w=%b a=%h d=%h busy=%b err=%b, want all 0", rf_write, rf_addr, rf_data, busy, err);
        end
        #1 reset_n = 1'b1;
        model_reset();
        cycle(0,0,0, 0,0,0, 1,1);
        cycle(0,0,0, 0,0,0, 1,3);
        cycle(0,0,0, 0,0,0, 1,2);
        cycle(1,2,16'h5555, 0,0,0, 0,0);
        checks++;
        if (busy !== 4'b1010 || rf_write !== 1'b1) begin
            errors++; $display("FAIL reset_setup: got busy=%b w=%b, want 1010 1", busy, rf_write);
        end
        req0_valid = 1; req1_valid = 1;
        #1;
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b1) begin
            errors++; $display("FAIL reset_prearm: got r0=%b r1=%b, want 0 1", req0_ready, req1_ready);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({req0_ready, req1_ready, rf_write, rf_addr, rf_data, busy, err} !== 26'h0) begin
            errors++; $display("FAIL reset_async: got r0=%b r1=%b w=%b a=%h d=%h busy=%b err=%b, want all 0",
                               req0_ready, req1_ready, rf_write, rf_addr, rf_data, busy, err);
        end
        #1 reset_n = 1'b1;
        idle_inputs();
        model_reset();
    endtask

    task automatic test_single();
        do_reset();
        cycle(0,0,0, 0,0,0, 1,2);
        checks++;
        if (busy !== 4'b0100) begin errors++; $display("FAIL single_issue: got busy=%b, want 0100", busy); end
        cycle(1,2,16'hABCD, 0,0,0, 0,0);
        checks++;
        if (obs_r0 !== 1'b1 || obs_r1 !== 1'b0) begin
            errors++; $display("FAIL single_ready: got r0=%b r1=%b, want 1 0", obs_r0, obs_r1);
        end
        checks++;
        if (rf_write !== 1'b1 || rf_addr !== 2'd2 || rf_data !== 16'hABCD || busy !== 4'b0000 || err !== 1'b0) begin
            errors++; $display("FAIL single_write: got w=%b a=%h d=%h busy=%b err=%b, want 1 2 abcd 0000 0",
                               rf_write, rf_addr, rf_data, busy, err);
        end
        cycle(0,0,0, 0,0,0, 0,0);
        checks++;
        if (rf_write !== 1'b0) begin errors++; $display("FAIL single_drop: got w=%b, want 0", rf_write); end
    endtask

    task automatic test_alternate();
        do_reset();
        cycle(0,0,0, 0,0,0, 1,1);
        cycle(0,0,0, 0,0,0, 1,3);
        for (int k = 0; k < 4; k++) begin
            cycle(1,1,16'h1111, 1,3,16'h3333, 1, (k % 2 == 0) ? 2'd1 : 2'd3);
            checks++;
            if (obs_r0 !== (k % 2 == 0) || obs_r1 !== (k % 2 == 1)) begin
                errors++; $display("FAIL alt_grant%0d: got r0=%b r1=%b, want %b %b", k, obs_r0, obs_r1, k % 2 == 0, k % 2 == 1);
            end
            checks++;
            if (rf_write !== 1'b1 || rf_data !== ((k % 2 == 0) ? 16'h1111 : 16'h3333) || err !== 1'b0) begin
                errors++; $display("FAIL alt_data%0d: got w=%b d=%h err=%b, want 1 %h 0", k, rf_write, rf_data, err,
                                   (k % 2 == 0) ? 16'h1111 : 16'h3333);
            end
        end
    endtask

    task automatic test_prio_after_single();
        do_reset();
        cycle(0,0,0, 0,0,0, 1,3);
        cycle(0,0,0, 0,0,0, 1,1);
        cycle(0,0,0, 1,3,16'h0033, 1,3);
        checks++;
        if (obs_r1 !== 1'b1 || obs_r0 !== 1'b0) begin errors++; $display("FAIL prio_n: got r0=%b r1=%b, want 0 1", obs_r0, obs_r1); end
        cycle(1,1,16'h0011, 1,3,16'h0033, 1,1);
        checks++;
        if (obs_r0 !== 1'b1 || obs_r1 !== 1'b0) begin errors++; $display("FAIL prio_n1: got r0=%b r1=%b, want 1 0", obs_r0, obs_r1); end
        cycle(1,1,16'h0011, 1,3,16'h0033, 0,0);
        checks++;
        if (obs_r1 !== 1'b1 || obs_r0 !== 1'b0) begin errors++; $display("FAIL prio_n2: got r0=%b r1=%b, want 0 1", obs_r0, obs_r1); end
        checks++;
        if (rf_addr !== 2'd3 || rf_data !== 16'h0033 || err !== 1'b0 || busy !== 4'b0010) begin
            errors++; $display("FAIL prio_state: got a=%h d=%h err=%b busy=%b, want 3 0033 0 0010", rf_addr, rf_data, err, busy);
        end
    endtask

    task automatic test_same_cycle();
        do_reset();
        cycle(0,0,0, 0,0,0, 1,1);
        cycle(1,1,16'h7777, 0,0,0, 1,1);
        checks++;
        if (busy !== 4'b0010 || err !== 1'b0 || rf_write !== 1'b1 || rf_addr !== 2'd1) begin
            errors++; $display("FAIL same_cycle: got busy=%b err=%b w=%b a=%h, want 0010 0 1 1", busy, err, rf_write, rf_addr);
        end
    endtask

    task automatic test_err();
        do_reset();
        cycle(0,0,0, 0,0,0, 1,0);
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL err_first_issue: got err=%b, want 0", err); end
        cycle(0,0,0, 0,0,0, 1,0);
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL err_double_issue: got err=%b, want 1", err); end
        cycle(1,0,16'h0F0F, 0,0,0, 0,0);
        cycle(0,0,0, 0,0,0, 0,0);
        checks++;
        if (err !== 1'b1 || busy !== 4'b0000) begin
            errors++; $display("FAIL err_sticky: got err=%b busy=%b, want 1 0000", err, busy);
        end
        do_reset();
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL err_cleared: got err=%b, want 0", err); end
        cycle(0,0,0, 1,3,16'hBEEF, 0,0);
        checks++;
        if (err !== 1'b1 || rf_write !== 1'b1 || rf_addr !== 2'd3 || rf_data !== 16'hBEEF) begin
            errors++; $display("FAIL err_unreserved: got err=%b w=%b a=%h d=%h, want 1 1 3 beef", err, rf_write, rf_addr, rf_data);
        end
    endtask

    task automatic test_random();
        logic r0v, r1v, iv;
        logic [1:0] r0a, r1a, ia;
        logic [15:0] r0d, r1d;
        do_reset();
        r0v = 0; r1v = 0; r0a = 0; r1a = 0; r0d = 0; r1d = 0;
        for (int n = 0; n < 300; n++) begin
            if (!(r0v && !obs_r0) || n == 0) begin
                r0v = ($urandom % 3) != 0; r0a = 2'($urandom); r0d = 16'($urandom);
            end
            if (!(r1v && !obs_r1) || n == 0) begin
                r1v = ($urandom % 3) != 0; r1a = 2'($urandom); r1d = 16'($urandom);
            end
            iv = ($urandom % 2) != 0; ia = 2'($urandom);
            if (n == 150) do_reset();
            cycle(r0v, r0a, r0d, r1v, r1a, r1d, iv, ia);
            checks++;
            if (obs_r0 !== exp_r0 || obs_r1 !== exp_r1) begin
                errors++; $display("FAIL rand_ready%0d: got r0=%b r1=%b, want %b %b", n, obs_r0, obs_r1, exp_r0, exp_r1);
            end
            checks++;
            if (rf_write !== exp_wr || (exp_wr && (rf_addr !== exp_addr || rf_data !== exp_data))) begin
                errors++; $display("FAIL rand_port%0d: got w=%b a=%h d=%h, want %b %h %h", n, rf_write, rf_addr, rf_data, exp_wr, exp_addr, exp_data);
            end
            checks++;
            if (busy !== m_busy || err !== m_err) begin
                errors++; $display("FAIL rand_sb%0d: got busy=%b err=%b, want %b %b", n, busy, err, m_busy, m_err);
            end
        end
    endtask

    initial begin
        obs_r0 = 0; obs_r1 = 0;
        test_reset();
        test_single();
        test_alternate();
        test_prio_after_single();
        test_same_cycle();
        test_err();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
